pipeline_ctrl: RTL and testbench

Pipeline sequencing controller for the NeonFox CPU. It watches the execute-stage control outputs of the decode stage and generates four decode-stage controls: `hazard` (stall), `flush` (squash), `jmp_rst` and `brx_rst` (acknowledge held PC requests). It sits between the decode unit, the PC/branch logic and the data/IO bus ready signals.

---
 rtl/neonfox_pkg.sv | 21 ++
 rtl/sat_counter.sv | 29 ++
 rtl/pipeline_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neonfox_pkg.sv
// neonfox_pkg
//   Shared types and defaults for the NeonFox pipeline sequencing logic.
//   - pctl_state_t     : pipeline_ctrl FSM state encoding
//   - FLUSH_CYCLES_DEF : default number of flush cycles after a taken transfer
//   - TIMEOUT_DEF      : default bus-wait cycles before a stall fault
//   - TIMER_W          : width of the bus-wait timer
package neonfox_pkg;

    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StDwait  = 3'd1,
        StIowait = 3'd2,
        StFlush  = 3'd3,
        StFault  = 3'd4
    } pctl_state_t;

    localparam int unsigned FLUSH_CYCLES_DEF = 2;
    localparam int unsigned TIMEOUT_DEF      = 255;
    localparam int unsigned TIMER_W          = 8;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter. Increments on en, sticks at all-ones.
//   Ports:
//     clk   in  clock
//     rst   in  synchronous active-high reset, clears the count
//     en    in  increment enable
//     count out current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Pipeline sequencing controller for the NeonFox CPU. Watches the
//   execute-stage controls from decode and produces stall, squash and
//   PC-request acknowledges.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     pc_jmp, pc_call, pc_ret      held jump/call/return requests
//     pc_brx, brx_taken            conditional branch request and its outcome
//     data_ren, data_wren, d_ready data-memory access and completion
//     IO_ren, IO_wren, io_ready    IO access and completion
//     p_cache_miss                 program cache miss (stretches flush)
//     hazard                       combinational stall of decode/fetch
//     flush                        registered squash of the decoded instruction
//     jmp_rst, brx_rst             registered one-cycle request acknowledges
//     stall_timeout                sticky bus-wait fault
//     stall_cycles                 saturating count of hazard cycles
module pipeline_ctrl
    import neonfox_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_jmp,
    input  logic        pc_call,
    input  logic        pc_ret,
    input  logic        pc_brx,
    input  logic        brx_taken,
    input  logic        data_ren,
    input  logic        data_wren,
    input  logic        d_ready,
    input  logic        IO_ren,
    input  logic        IO_wren,
    input  logic        io_ready,
    input  logic        p_cache_miss,
    output logic        hazard,
    output logic        flush,
    output logic        jmp_rst,
    output logic        brx_rst,
    output logic        stall_timeout,
    output logic [15:0] stall_cycles
);

    localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0]     FCNT_LOAD = FCW'(FLUSH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(TIMEOUT - 1);

    pctl_state_t        r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [FCW-1:0]     r_fcnt;
    logic               r_flush;
    logic               r_jmp_rst;
    logic               r_brx_rst;
    logic               r_stall_timeout;

    logic w_dacc;
    logic w_iacc;
    logic w_dstall;
    logic w_istall;
    logic w_hazard;

    always_comb begin
        w_dacc   = data_ren | data_wren;
        w_iacc   = IO_ren | IO_wren;
        w_dstall = w_dacc & ~d_ready;
        w_istall = w_iacc & ~io_ready;
        w_hazard = 1'b0;
        unique case (r_state)
            StRun:    w_hazard = w_dstall | w_istall;
            StDwait:  w_hazard = ~d_ready;
            StIowait: w_hazard = ~io_ready;
            StFault:  w_hazard = 1'b1;
            default:  w_hazard = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= StRun;
            r_timer         <= '0;
            r_fcnt          <= '0;
            r_flush         <= 1'b0;
            r_jmp_rst       <= 1'b0;
            r_brx_rst       <= 1'b0;
            r_stall_timeout <= 1'b0;
        end else begin
            // Acknowledges are single-cycle pulses by construction.
            r_jmp_rst <= 1'b0;
            r_brx_rst <= 1'b0;
            unique case (r_state)
                StRun: begin
                    // Stalls outrank transfers; decode holds the transfer until
                    // the wait has resolved.
                    if (w_dstall) begin
                        r_state <= StDwait;
                        r_timer <= '0;
                    end else if (w_istall) begin
                        r_state <= StIowait;
                        r_timer <= '0;
                    end else if (pc_jmp || pc_call) begin
                        r_jmp_rst <= 1'b1;
                        r_state   <= StFlush;
                        r_flush   <= 1'b1;
                        r_fcnt    <= FCNT_LOAD;
                    end else if (pc_ret) begin
                        r_state <= StFlush;
                        r_flush <= 1'b1;
                        r_fcnt  <= FCNT_LOAD;
                    end else if (pc_brx) begin
                        r_brx_rst <= 1'b1;
                        if (brx_taken) begin
                            r_state <= StFlush;
                            r_flush <= 1'b1;
                            r_fcnt  <= FCNT_LOAD;
                        end
                    end
                end
                StDwait: begin
                    if (d_ready) begin
                        r_state <= StRun;
                        r_timer <= '0;
                    end else if (r_timer == TMO_LAST) begin
                        r_state         <= StFault;
                        r_stall_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                StIowait: begin
                    if (io_ready) begin
                        r_state <= StRun;
                        r_timer <= '0;
                    end else if (r_timer == TMO_LAST) begin
                        r_state         <= StFault;
                        r_stall_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                StFlush: begin
                    // A cache miss freezes the countdown, stretching the flush.
                    if (!p_cache_miss) begin
                        if (r_fcnt == '0) begin
                            r_state <= StRun;
                            r_flush <= 1'b0;
                        end else begin
                            r_fcnt <= r_fcnt - FCW'(1);
                        end
                    end
                end
                StFault: begin
                    r_stall_timeout <= 1'b1;
                end
                default: begin
                    r_state <= StRun;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_hazard),
        .count (stall_cycles)
    );

    assign hazard        = w_hazard;
    assign flush         = r_flush;
    assign jmp_rst       = r_jmp_rst;
    assign brx_rst       = r_brx_rst;
    assign stall_timeout = r_stall_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl. Each cycle's expected hazard/flush/
//   jmp_rst/brx_rst is queued when the inputs are driven and compared at the
//   following negedge.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        pc_jmp, pc_call, pc_ret, pc_brx, brx_taken;
    logic        data_ren, data_wren, d_ready;
    logic        IO_ren, IO_wren, io_ready;
    logic        p_cache_miss;
    logic        hazard, flush, jmp_rst, brx_rst, stall_timeout;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic h;
        logic f;
        logic j;
        logic b;
    } exp_t;

    exp_t sb[$];

    pipeline_ctrl #(
        .FLUSH_CYCLES (2),
        .TIMEOUT      (255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_jmp        (pc_jmp),
        .pc_call       (pc_call),
        .pc_ret        (pc_ret),
        .pc_brx        (pc_brx),
        .brx_taken     (brx_taken),
        .data_ren      (data_ren),
        .data_wren     (data_wren),
        .d_ready       (d_ready),
        .IO_ren        (IO_ren),
        .IO_wren       (IO_wren),
        .io_ready      (io_ready),
        .p_cache_miss  (p_cache_miss),
        .hazard        (hazard),
        .flush         (flush),
        .jmp_rst       (jmp_rst),
        .brx_rst       (brx_rst),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        pc_jmp = 0; pc_call = 0; pc_ret = 0; pc_brx = 0; brx_taken = 0;
        data_ren = 0; data_wren = 0; d_ready = 0;
        IO_ren = 0; IO_wren = 0; io_ready = 0; p_cache_miss = 0;
    endtask

    // Called just after a posedge with inputs already set for this cycle.
    task automatic cyc(input string tag, input logic h, input logic f,
                       input logic j, input logic b);
        exp_t e;
        e = '{h: h, f: f, j: j, b: b};
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".hazard"},  32'(hazard),  32'(e.h));
        chk({tag, ".flush"},   32'(flush),   32'(e.f));
        chk({tag, ".jmp_rst"}, 32'(jmp_rst), 32'(e.j));
        chk({tag, ".brx_rst"}, 32'(brx_rst), 32'(e.b));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        logic haz_ok;
        rst = 1'b1;
        idle_inputs();

        // Reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.hazard", 32'(hazard), 0);
        chk("rst.flush", 32'(flush), 0);
        chk("rst.jmp_rst", 32'(jmp_rst), 0);
        chk("rst.brx_rst", 32'(brx_rst), 0);
        chk("rst.timeout", 32'(stall_timeout), 0);
        chk("rst.stall_cycles", 32'(stall_cycles), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Data stall: ready low 3 cycles, then high
        data_ren = 1; d_ready = 0;
        cyc("dst0", 1, 0, 0, 0);
        cyc("dst1", 1, 0, 0, 0);
        cyc("dst2", 1, 0, 0, 0);
        d_ready = 1;
        cyc("dst_rdy", 0, 0, 0, 0);
        idle_inputs();
        cyc("dst_idle", 0, 0, 0, 0);
        chk("dst.stall_cycles", 32'(stall_cycles), 3);

        // Ready on the first access cycle: no stall
        data_wren = 1; d_ready = 1;
        cyc("dfast", 0, 0, 0, 0);
        idle_inputs();
        cyc("dfast_idle", 0, 0, 0, 0);
        chk("dfast.stall_cycles", 32'(stall_cycles), 3);

        // Jump: ack at t+1, flush t+1..t+2, RUN at t+3
        pc_jmp = 1;
        cyc("jmp_t0", 0, 0, 0, 0);
        cyc("jmp_t1", 0, 1, 1, 0);
        pc_jmp = 0;
        cyc("jmp_t2", 0, 1, 0, 0);
        cyc("jmp_t3", 0, 0, 0, 0);

        // Not-taken branch: ack only
        pc_brx = 1; brx_taken = 0;
        cyc("bnt_t0", 0, 0, 0, 0);
        idle_inputs();
        cyc("bnt_t1", 0, 0, 0, 1);
        cyc("bnt_t2", 0, 0, 0, 0);

        // Taken branch: ack plus 2-cycle flush
        pc_brx = 1; brx_taken = 1;
        cyc("bt_t0", 0, 0, 0, 0);
        idle_inputs();
        cyc("bt_t1", 0, 1, 0, 1);
        cyc("bt_t2", 0, 1, 0, 0);
        cyc("bt_t3", 0, 0, 0, 0);

        // Taken branch with 2 miss cycles: flush stretched to 4
        pc_brx = 1; brx_taken = 1;
        cyc("btm_t0", 0, 0, 0, 0);
        idle_inputs();
        p_cache_miss = 1;
        cyc("btm_t1", 0, 1, 0, 1);
        cyc("btm_t2", 0, 1, 0, 0);
        p_cache_miss = 0;
        cyc("btm_t3", 0, 1, 0, 0);
        cyc("btm_t4", 0, 1, 0, 0);
        cyc("btm_t5", 0, 0, 0, 0);

        // Return: flush without any acknowledge
        pc_ret = 1;
        cyc("ret_t0", 0, 0, 0, 0);
        pc_ret = 0;
        cyc("ret_t1", 0, 1, 0, 0);
        cyc("ret_t2", 0, 1, 0, 0);
        cyc("ret_t3", 0, 0, 0, 0);

        // IO stall: 2 wait cycles
        IO_ren = 1; io_ready = 0;
        cyc("iost0", 1, 0, 0, 0);
        cyc("iost1", 1, 0, 0, 0);
        io_ready = 1;
        cyc("iost_rdy", 0, 0, 0, 0);
        idle_inputs();
        cyc("iost_idle", 0, 0, 0, 0);
        chk("iost.stall_cycles", 32'(stall_cycles), 5);

        // Data stall coincident with call: transfer is evaluated only once
        // back in RUN, the cycle after ready, so jmp_rst lands one later.
        data_ren = 1; d_ready = 0; pc_call = 1;
        cyc("dcall_t0", 1, 0, 0, 0);
        cyc("dcall_t1", 1, 0, 0, 0);
        d_ready = 1;
        cyc("dcall_rdy", 0, 0, 0, 0);
        data_ren = 0; d_ready = 0;
        cyc("dcall_acc", 0, 0, 0, 0);
        pc_call = 0;
        cyc("dcall_ack", 0, 1, 1, 0);
        cyc("dcall_fl2", 0, 1, 0, 0);
        cyc("dcall_run", 0, 0, 0, 0);
        chk("dcall.stall_cycles", 32'(stall_cycles), 7);

        // IO timeout: 1 RUN stall cycle + 255 wait cycles, then FAULT
        IO_wren = 1; io_ready = 0;
        n = 0;
        haz_ok = 1'b1;
        while (n < 400) begin
            @(negedge clk);
            if (stall_timeout) break;
            if (hazard !== 1'b1) haz_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk("tmo.latency", 32'(n), 256);
        chk("tmo.hazard_during_wait", 32'(haz_ok), 1);
        chk("tmo.hazard", 32'(hazard), 1);
        chk("tmo.stall_timeout", 32'(stall_timeout), 1);
        chk("tmo.stall_cycles", 32'(stall_cycles), 7 + 256);
        @(posedge clk);
        #1;
        // FAULT holds even once the bus answers
        io_ready = 1;
        @(negedge clk);
        chk("fault.hazard_held", 32'(hazard), 1);
        chk("fault.timeout_held", 32'(stall_timeout), 1);
        @(posedge clk);
        #1;

        // Reset out of FAULT
        rst = 1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst.hazard", 32'(hazard), 0);
        chk("post_rst.timeout", 32'(stall_timeout), 0);
        chk("post_rst.stall_cycles", 32'(stall_cycles), 0);
        chk("post_rst.flush", 32'(flush), 0);
        @(posedge clk);
        #1;

        // Back in RUN: a not-taken branch is acknowledged normally
        pc_brx = 1;
        cyc("prb_t0", 0, 0, 0, 0);
        idle_inputs();
        cyc("prb_t1", 0, 0, 0, 1);

        // Reset mid-flush
        pc_jmp = 1;
        cyc("rfl_t0", 0, 0, 0, 0);
        pc_jmp = 0;
        rst = 1;
        cyc("rfl_t1", 0, 1, 1, 0);
        rst = 0;
        cyc("rfl_t2", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
